fp_addsub: RTL and testbench

Parametrised IEEE-754 binary floating-point adder/subtractor with stb/ack handshakes on both operands and the result. It is the next generation of the fixed 64-bit `double_adder`. Format width is set by parameters: double by default, single or custom by override. It adds a subtract mode, round-to-nearest-even, gradual underflow, exception flags and a fixed, verifiable latency. It sits on the same operand/result handshake fabric as the existing FP units.

---
 rtl/fp_addsub.sv | 323 ++++++++++++++++++++++++++++++++
 tb/tb_fp_addsub.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fp_addsub.sv
// fp_addsub: parametrised IEEE-754 binary adder/subtractor.
// It takes operands A and B/op over stb/ack handshakes and returns the
// result and flags {invalid, overflow, inexact} over a stb/ack handshake.
// The datapath runs as a fixed chain of FSM states:
// UNPACK, ALIGN, ADD, NORM, ROUND and PACK, each taking one cycle.
// Special operands (NaN, Inf) are resolved in UNPACK. They then ride the
// same states as a bypass, so every result has the same latency.
module fp_addsub #(
    parameter int EXP_W  = 11,
    parameter int FRAC_W = 52
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [EXP_W+FRAC_W:0]     input_a,
    input  logic                      input_a_stb,
    output logic                      input_a_ack,
    input  logic [EXP_W+FRAC_W:0]     input_b,
    input  logic                      input_op,
    input  logic                      input_b_stb,
    output logic                      input_b_ack,
    output logic [EXP_W+FRAC_W:0]     output_z,
    output logic                      output_z_stb,
    input  logic                      output_z_ack,
    output logic [2:0]                output_flags
);
    localparam int W  = 1 + EXP_W + FRAC_W;
    // The significand is hidden bit, fraction, then guard, round and sticky.
    localparam int SW = FRAC_W + 4;
    localparam logic [EXP_W-1:0]  EXP_ONES = '1;
    localparam logic [EXP_W-1:0]  EXP_ZERO = '0;
    localparam logic [FRAC_W-1:0] FRAC_ZERO = '0;
    localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(FRAC_W-1){1'b0}}};

    typedef enum logic [3:0] {
        GET_A, GET_B, UNPACK, ALIGN, ADD, NORM, ROUND, PACK, PUT_Z
    } state_t;

    state_t state_q;

    logic             a_ack_q, b_ack_q, z_stb_q;
    logic [W-1:0]     a_q, b_q, z_q;
    logic             op_q;
    logic [2:0]       flags_q;

    // UNPACK results
    logic             sa_q, sb_q;
    logic [EXP_W:0]   ea_q, eb_q;
    logic [SW-1:0]    ma_q, mb_q;
    logic             spec_q;
    logic [W-1:0]     spec_z_q;
    logic [2:0]       spec_f_q;
    // Results of the ALIGN state onwards. The exponent register has one
    // spare bit so that a carry, or a round-up, past all-ones stays visible.
    logic             sx_q, sy_q, sign_q, inexact_q;
    logic [EXP_W:0]   e_q;
    logic [SW-1:0]    mx_q, my_q, nm_q;
    logic [SW:0]      sum_q;
    logic [FRAC_W:0]  rm_q;

    // Next-state values, one group per datapath state
    logic             sa_d, sb_d, spec_d;
    logic [EXP_W:0]   ea_d, eb_d;
    logic [SW-1:0]    ma_d, mb_d;
    logic [W-1:0]     spec_z_d;
    logic [2:0]       spec_f_d;
    logic             sx_d, sy_d;
    logic [EXP_W:0]   ex_d;
    logic [SW-1:0]    mx_d, my_d;
    logic [SW:0]      sum_d;
    logic             sign_d;
    logic [EXP_W:0]   ne_d;
    logic [SW-1:0]    nm_d;
    logic [EXP_W:0]   re_d;
    logic [FRAC_W:0]  rm_d;
    logic             inexact_d;
    logic [W-1:0]     z_d;
    logic [2:0]       flags_d;

    // UNPACK: split the fields, apply the effective sign of B, resolve specials
    always_comb begin
        logic [EXP_W-1:0]  fea, feb;
        logic [FRAC_W-1:0] fra, frb;
        logic nan_a, nan_b, snan_a, snan_b, inf_a, inf_b;
        fea = a_q[FRAC_W +: EXP_W];
        feb = b_q[FRAC_W +: EXP_W];
        fra = a_q[FRAC_W-1:0];
        frb = b_q[FRAC_W-1:0];
        sa_d = a_q[W-1];
        sb_d = b_q[W-1] ^ op_q;
        ea_d = (fea == EXP_ZERO) ? {{EXP_W{1'b0}}, 1'b1} : {1'b0, fea};
        eb_d = (feb == EXP_ZERO) ? {{EXP_W{1'b0}}, 1'b1} : {1'b0, feb};
        ma_d = {fea != EXP_ZERO, fra, 3'b000};
        mb_d = {feb != EXP_ZERO, frb, 3'b000};
        nan_a  = (fea == EXP_ONES) && (fra != FRAC_ZERO);
        nan_b  = (feb == EXP_ONES) && (frb != FRAC_ZERO);
        snan_a = nan_a && !fra[FRAC_W-1];
        snan_b = nan_b && !frb[FRAC_W-1];
        inf_a  = (fea == EXP_ONES) && (fra == FRAC_ZERO);
        inf_b  = (feb == EXP_ONES) && (frb == FRAC_ZERO);
        spec_d   = 1'b1;
        spec_z_d = QNAN;
        spec_f_d = 3'b000;
        if (nan_a || nan_b) begin
            spec_f_d = {snan_a | snan_b, 2'b00};
        end else if (inf_a && inf_b && (sa_d != sb_d)) begin
            spec_f_d = 3'b100;
        end else if (inf_a) begin
            spec_z_d = {sa_d, EXP_ONES, FRAC_ZERO};
        end else if (inf_b) begin
            spec_z_d = {sb_d, EXP_ONES, FRAC_ZERO};
        end else begin
            spec_d = 1'b0;
        end
    end

    // ALIGN: right-shift the smaller-exponent significand and fold the
    // shifted-out bits into sticky
    always_comb begin
        logic [EXP_W:0]  d;
        logic [SW-1:0]   ms, sh;
        logic            lost;
        if (ea_q >= eb_q) begin
            ex_d = ea_q; mx_d = ma_q; sx_d = sa_q; ms = mb_q; sy_d = sb_q;
            d = ea_q - eb_q;
        end else begin
            ex_d = eb_q; mx_d = mb_q; sx_d = sb_q; ms = ma_q; sy_d = sa_q;
            d = eb_q - ea_q;
        end
        lost = 1'b0;
        if (int'(d) >= SW) begin
            sh   = '0;
            lost = |ms;
        end else begin
            sh = ms >> d;
            for (int i = 0; i < SW; i++)
                if (i < int'(d)) lost = lost | ms[i];
        end
        my_d = {sh[SW-1:1], sh[0] | lost};
    end

    // ADD: magnitude add or subtract; an exact cancellation gives +0
    always_comb begin
        if (sx_q == sy_q) begin
            sum_d  = {1'b0, mx_q} + {1'b0, my_q};
            sign_d = sx_q;
        end else if (mx_q >= my_q) begin
            sum_d  = {1'b0, mx_q - my_q};
            sign_d = sx_q;
        end else begin
            sum_d  = {1'b0, my_q - mx_q};
            sign_d = sy_q;
        end
        if ((sx_q != sy_q) && (sum_d == '0)) sign_d = 1'b0;
    end

    // NORM: fold a carry back in, or left-normalise but stop at exponent 1
    // (subnormal)
    always_comb begin
        int lz, lim, shn;
        lz  = SW;
        lim = 0;
        shn = 0;
        if (sum_q[SW]) begin
            nm_d = {sum_q[SW:2], sum_q[1] | sum_q[0]};
            ne_d = e_q + 1'b1;
        end else begin
            for (int i = 0; i < SW; i++)
                if (sum_q[i]) lz = SW - 1 - i;
            lim  = int'(e_q) - 1;
            shn  = (lz < lim) ? lz : lim;
            nm_d = sum_q[SW-1:0] << shn;
            ne_d = e_q - (EXP_W+1)'(shn);
        end
    end

    // ROUND: round to nearest, ties to even, on guard/round/sticky
    always_comb begin
        logic [FRAC_W:0]   keep;
        logic [FRAC_W+1:0] rnd;
        logic              up;
        keep      = nm_q[SW-1:3];
        up        = nm_q[2] & (nm_q[1] | nm_q[0] | keep[0]);
        inexact_d = |nm_q[2:0];
        rnd       = {1'b0, keep} + {{(FRAC_W+1){1'b0}}, up};
        if (rnd[FRAC_W+1]) begin
            rm_d = rnd[FRAC_W+1:1];
            re_d = e_q + 1'b1;
        end else begin
            rm_d = rnd[FRAC_W:0];
            re_d = e_q;
        end
    end

    // PACK: overflow to Inf, subnormal encoding, special bypass
    always_comb begin
        if (spec_q) begin
            z_d     = spec_z_q;
            flags_d = spec_f_q;
        end else if (e_q >= {1'b0, EXP_ONES}) begin
            z_d     = {sign_q, EXP_ONES, FRAC_ZERO};
            flags_d = 3'b011;
        end else begin
            z_d     = {sign_q, rm_q[FRAC_W] ? e_q[EXP_W-1:0] : EXP_ZERO,
                       rm_q[FRAC_W-1:0]};
            flags_d = {2'b00, inexact_q};
        end
    end

    // Control FSM with registered handshakes; each datapath state latches its stage result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= GET_A;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            z_stb_q   <= 1'b0;
            z_q       <= '0;
            flags_q   <= '0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            ea_q      <= '0;
            eb_q      <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            spec_q    <= 1'b0;
            spec_z_q  <= '0;
            spec_f_q  <= '0;
            sx_q      <= 1'b0;
            sy_q      <= 1'b0;
            sign_q    <= 1'b0;
            inexact_q <= 1'b0;
            e_q       <= '0;
            mx_q      <= '0;
            my_q      <= '0;
            nm_q      <= '0;
            sum_q     <= '0;
            rm_q      <= '0;
        end else begin
            case (state_q)
                GET_A: begin
                    if (a_ack_q && input_a_stb) begin
                        a_q     <= input_a;
                        a_ack_q <= 1'b0;
                        b_ack_q <= 1'b1;
                        state_q <= GET_B;
                    end else begin
                        a_ack_q <= 1'b1;
                    end
                end
                GET_B: begin
                    if (b_ack_q && input_b_stb) begin
                        b_q     <= input_b;
                        op_q    <= input_op;
                        b_ack_q <= 1'b0;
                        state_q <= UNPACK;
                    end else begin
                        b_ack_q <= 1'b1;
                    end
                end
                UNPACK: begin
                    sa_q     <= sa_d;
                    sb_q     <= sb_d;
                    ea_q     <= ea_d;
                    eb_q     <= eb_d;
                    ma_q     <= ma_d;
                    mb_q     <= mb_d;
                    spec_q   <= spec_d;
                    spec_z_q <= spec_z_d;
                    spec_f_q <= spec_f_d;
                    state_q  <= ALIGN;
                end
                ALIGN: begin
                    sx_q    <= sx_d;
                    sy_q    <= sy_d;
                    e_q     <= ex_d;
                    mx_q    <= mx_d;
                    my_q    <= my_d;
                    state_q <= ADD;
                end
                ADD: begin
                    sum_q   <= sum_d;
                    sign_q  <= sign_d;
                    state_q <= NORM;
                end
                NORM: begin
                    nm_q    <= nm_d;
                    e_q     <= ne_d;
                    state_q <= ROUND;
                end
                ROUND: begin
                    rm_q      <= rm_d;
                    e_q       <= re_d;
                    inexact_q <= inexact_d;
                    state_q   <= PACK;
                end
                PACK: begin
                    z_q     <= z_d;
                    flags_q <= flags_d;
                    z_stb_q <= 1'b1;
                    state_q <= PUT_Z;
                end
                PUT_Z: begin
                    // Re-arm the A ack on the consume edge to keep the 9-cycle throughput.
                    if (output_z_ack) begin
                        z_stb_q <= 1'b0;
                        a_ack_q <= 1'b1;
                        state_q <= GET_A;
                    end
                end
                default: state_q <= GET_A;
            endcase
        end
    end

    assign input_a_ack  = a_ack_q;
    assign input_b_ack  = b_ack_q;
    assign output_z     = z_q;
    assign output_z_stb = z_stb_q;
    assign output_flags = flags_q;

endmodule

// File: tb/tb_fp_addsub.sv
// Directed bench for fp_addsub. It uses a double-precision instance and a
// single-precision instance that share one clock and reset.
module tb_fp_addsub;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [63:0] da, db, dz;
    logic        dop, da_stb, db_stb, dz_ack, da_ack, db_ack, dz_stb;
    logic [2:0]  dfl;
    logic [31:0] sa, sb, sz;
    logic        sop, sa_stb, sb_stb, sz_ack, sa_ack, sb_ack, sz_stb;
    logic [2:0]  sfl;

    fp_addsub dut_d (
        .clk(clk), .rst(rst),
        .input_a(da), .input_a_stb(da_stb), .input_a_ack(da_ack),
        .input_b(db), .input_op(dop), .input_b_stb(db_stb), .input_b_ack(db_ack),
        .output_z(dz), .output_z_stb(dz_stb), .output_z_ack(dz_ack),
        .output_flags(dfl)
    );

    fp_addsub #(.EXP_W(8), .FRAC_W(23)) dut_s (
        .clk(clk), .rst(rst),
        .input_a(sa), .input_a_stb(sa_stb), .input_a_ack(sa_ack),
        .input_b(sb), .input_op(sop), .input_b_stb(sb_stb), .input_b_ack(sb_ack),
        .output_z(sz), .output_z_stb(sz_stb), .output_z_ack(sz_ack),
        .output_flags(sfl)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic f_a_ack(input bit sp);  return sp ? sa_ack : da_ack; endfunction
    function automatic logic f_b_ack(input bit sp);  return sp ? sb_ack : db_ack; endfunction
    function automatic logic f_z_stb(input bit sp);  return sp ? sz_stb : dz_stb; endfunction
    function automatic logic [63:0] f_z(input bit sp); return sp ? {32'b0, sz} : dz; endfunction
    function automatic logic [2:0] f_fl(input bit sp); return sp ? sfl : dfl; endfunction

    // Hand over A and B. Scramble the inputs after the B edge. Count edges until z_stb.
    task automatic issue(input bit sp, input logic [63:0] a, input logic [63:0] b,
                         input logic op, output int lat);
        int n;
        if (sp) begin sa = a[31:0]; sb = b[31:0]; sop = op; sa_stb = 1; sb_stb = 1; end
        else    begin da = a;       db = b;       dop = op; da_stb = 1; db_stb = 1; end
        n = 0;
        while (!f_a_ack(sp) && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) check("a_ack_timeout", f_a_ack(sp), 1);
        @(posedge clk); #1;
        if (sp) sa_stb = 0; else da_stb = 0;
        n = 0;
        while (!f_b_ack(sp) && n < 20) begin @(posedge clk); #1; n++; end
        if (n == 20) check("b_ack_timeout", f_b_ack(sp), 1);
        @(posedge clk); #1;
        if (sp) begin sb_stb = 0; sa = $urandom; sb = $urandom; sop = ~op; end
        else begin db_stb = 0; da = {$urandom, $urandom}; db = {$urandom, $urandom}; dop = ~op; end
        lat = 0;
        while (!f_z_stb(sp) && lat < 20) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic take_z(input bit sp);
        if (sp) sz_ack = 1; else dz_ack = 1;
        @(posedge clk); #1;
        if (sp) sz_ack = 0; else dz_ack = 0;
        check("z_stb_drop", f_z_stb(sp), 0);
        check("a_ack_rearm", f_a_ack(sp), 1);
    endtask

    task automatic run(input string tag, input bit sp, input logic [63:0] a,
                       input logic [63:0] b, input logic op,
                       input logic [63:0] ez, input logic [2:0] efl);
        int lat;
        issue(sp, a, b, op, lat);
        check({tag, "_lat"}, 64'(lat), 64'd6);
        check({tag, "_z"}, f_z(sp), ez);
        check({tag, "_flags"}, 64'(f_fl(sp)), 64'(efl));
        take_z(sp);
    endtask

    initial begin
        logic [63:0] zh;
        logic [2:0]  fh;
        logic        seen;
        int          lat;
        rst = 1;
        da = '0; db = '0; dop = 0; da_stb = 0; db_stb = 0; dz_ack = 0;
        sa = '0; sb = '0; sop = 0; sa_stb = 0; sb_stb = 0; sz_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_a_ack", da_ack, 0);
        check("rst_b_ack", db_ack, 0);
        check("rst_z_stb", dz_stb, 0);
        check("rst_z", dz, 0);
        check("rst_flags", dfl, 0);
        rst = 0;
        @(posedge clk); #1;
        check("a_ack_after_rst", da_ack, 1);

        run("add_basic", 0, 64'h405576F31210A3BC, 64'h404D4B55E586E60C, 0, 64'h40620E4F026A0B61, 3'b000);
        run("cancel",    0, 64'h3FF0000000000000, 64'h3FF0000000000000, 1, 64'h0000000000000000, 3'b000);
        run("negzero",   0, 64'h8000000000000000, 64'h8000000000000000, 0, 64'h8000000000000000, 3'b000);
        run("inf_m_inf", 0, 64'h7FF0000000000000, 64'hFFF0000000000000, 0, 64'h7FF8000000000000, 3'b100);
        run("inf_sub",   0, 64'h7FF0000000000000, 64'h7FF0000000000000, 1, 64'h7FF8000000000000, 3'b100);
        run("overflow",  0, 64'h7FEFFFFFFFFFFFFF, 64'h7FEFFFFFFFFFFFFF, 0, 64'h7FF0000000000000, 3'b011);
        run("subnorm",   0, 64'h0000000000000001, 64'h0000000000000001, 0, 64'h0000000000000002, 3'b000);
        run("sub_to_sn", 0, 64'h0010000000000000, 64'h0000000000000001, 1, 64'h000FFFFFFFFFFFFF, 3'b000);
        run("one_m_half",0, 64'h3FF0000000000000, 64'h3FE0000000000000, 1, 64'h3FE0000000000000, 3'b000);
        run("snan",      0, 64'h7FF0000000000001, 64'h3FF0000000000000, 0, 64'h7FF8000000000000, 3'b100);
        run("qnan",      0, 64'h3FF0000000000000, 64'h7FF8000000000123, 0, 64'h7FF8000000000000, 3'b000);
        run("ninf_m_1",  0, 64'hFFF0000000000000, 64'h3FF0000000000000, 1, 64'hFFF0000000000000, 3'b000);
        run("sp_tie",    1, 64'h3F800000, 64'h33800000, 0, 64'h3F800000, 3'b001);
        run("sp_rnd_up", 1, 64'h3F800001, 64'h33800000, 0, 64'h3F800002, 3'b001);

        // Backpressure: hold z_ack low and expect a stable result and no new A ack.
        issue(0, 64'h3FF0000000000000, 64'h3FF0000000000000, 0, lat);
        check("bp_lat", 64'(lat), 64'd6);
        zh = dz; fh = dfl;
        check("bp_z", zh, 64'h4000000000000000);
        repeat (5) begin
            @(posedge clk); #1;
            check("bp_z_stable", dz, zh);
            check("bp_fl_stable", dfl, fh);
            check("bp_stb_held", dz_stb, 1);
            check("bp_no_a_ack", da_ack, 0);
        end
        take_z(0);

        // Reset 3 cycles after the B handshake discards the operation.
        da = 64'h3FF0000000000000; da_stb = 1;
        @(posedge clk); #1;
        da_stb = 0; db = 64'h3FF0000000000000; db_stb = 1; dop = 0;
        check("rst_seq_b_ack", db_ack, 1);
        @(posedge clk); #1;
        db_stb = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk); #1;
        check("midrst_z_stb", dz_stb, 0);
        check("midrst_z", dz, 0);
        check("midrst_a_ack", da_ack, 0);
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        check("midrst_a_ack_rise", da_ack, 1);
        seen = 0;
        repeat (8) begin
            @(posedge clk); #1;
            seen = seen | dz_stb;
        end
        check("midrst_no_z", seen, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
